// File: rtl/gesture_servo_driver.sv
// -----------------------------------------------------------------------------
// gesture_servo_driver
//
// Drives five hobby-servo PWM lines (one per finger) from a latched gesture
// code. A free-running frame counter defines the servo frame. On the last
// cycle of each frame (the "boundary"), the gesture is sampled into per-finger
// targets. Each finger position then moves toward its target. The new
// positions set the pulse widths for the whole of the next frame.
//
// Optional feature macro: GESTURE_SLEW_EN
//   defined   : each boundary moves a position at most STEP cycles toward
//               its target (no overshoot).
//   undefined : each non-frozen boundary jumps the positions straight to
//               their targets; STEP only takes part in the parameter check.
//
// Parameters
//   PERIOD_CYCLES : frame length in clk cycles
//   MIN_PULSE     : pulse width for an open finger
//   MAX_PULSE     : pulse width for a closed finger
//   STEP          : largest position change per channel per frame (slew build)
//
// Ports
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset
//   gesture    : [4:0] finger closed(1)/open(0), [7] freeze, [6:5] ignored
//   servo_pwm  : registered PWM line per finger, bit i = finger i
//   frame_tick : registered one-cycle pulse on the last cycle of each frame
//   busy       : registered, high while any position differs from its target
// -----------------------------------------------------------------------------
module gesture_servo_driver #(
  parameter int unsigned PERIOD_CYCLES = 1000000,
  parameter int unsigned MIN_PULSE     = 50000,
  parameter int unsigned MAX_PULSE     = 100000,
  parameter int unsigned STEP          = 2500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] gesture,
  output logic [4:0] servo_pwm,
  output logic       frame_tick,
  output logic       busy
);

  localparam int unsigned CW  = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam int          NCH = 5;

  localparam logic [CW-1:0] LAST_C = CW'(PERIOD_CYCLES - 32'd1);
  localparam logic [CW-1:0] MIN_C  = CW'(MIN_PULSE);
  localparam logic [CW-1:0] MAX_C  = CW'(MAX_PULSE);
  localparam logic [CW-1:0] ONE_C  = CW'(32'd1);

  // Refuse to elaborate with a parameter set that cannot produce sane pulses.
  if ((STEP < 32'd1) || (MIN_PULSE >= MAX_PULSE) || (MAX_PULSE >= PERIOD_CYCLES)) begin : g_bad_params
    $error("gesture_servo_driver: illegal parameter set");
  end

`ifdef GESTURE_SLEW_EN
  // Every difference is below PERIOD_CYCLES, so clamping a larger STEP to
  // PERIOD_CYCLES-1 keeps the behaviour and avoids truncating it.
  localparam logic [CW-1:0] STEP_C = (STEP >= PERIOD_CYCLES) ? LAST_C : CW'(STEP);

  // Move cur at most STEP_C toward tgt. Land exactly on tgt when it is
  // within reach, so a position can never overshoot.
  function automatic logic [CW-1:0] slew_toward(input logic [CW-1:0] cur,
                                                input logic [CW-1:0] tgt);
    logic [CW-1:0] res;
    if (tgt > cur) begin
      if ((tgt - cur) <= STEP_C) begin
        res = tgt;
      end else begin
        res = cur + STEP_C;
      end
    end else begin
      if ((cur - tgt) <= STEP_C) begin
        res = tgt;
      end else begin
        res = cur - STEP_C;
      end
    end
    return res;
  endfunction
`endif

  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt_s;
  logic          boundary_s;

  logic [CW-1:0] pos_r     [NCH];
  logic [CW-1:0] tgt_r     [NCH];
  logic [CW-1:0] pos_nxt_s [NCH];
  logic [CW-1:0] tgt_nxt_s [NCH];

  logic [4:0]    pwm_r;
  logic [4:0]    pwm_nxt_s;
  logic          frame_tick_r;
  logic          busy_r;
  logic          busy_nxt_s;

  // Bits [6:5] of the gesture code carry nothing for this block.
  logic          unused_gesture_s;
  assign unused_gesture_s = ^gesture[6:5];

  // Frame counter next value; the boundary is the last cycle of the frame.
  always_comb begin
    boundary_s = (cnt_r == LAST_C);
    if (boundary_s) begin
      cnt_nxt_s = {CW{1'b0}};
    end else begin
      cnt_nxt_s = cnt_r + ONE_C;
    end
  end

  // Boundary update of targets and positions; everything holds in between
  // so a pulse already running is never stretched or cut short.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      tgt_nxt_s[i] = tgt_r[i];
      pos_nxt_s[i] = pos_r[i];
    end
    if (boundary_s && !gesture[7]) begin
      for (int i = 0; i < NCH; i++) begin
        tgt_nxt_s[i] = gesture[i] ? MAX_C : MIN_C;
`ifdef GESTURE_SLEW_EN
        pos_nxt_s[i] = slew_toward(pos_r[i], tgt_nxt_s[i]);
`else
        pos_nxt_s[i] = tgt_nxt_s[i];
`endif
      end
    end else begin
      // Mid-frame, or frozen boundary: keep the committed state.
      for (int i = 0; i < NCH; i++) begin
        tgt_nxt_s[i] = tgt_r[i];
        pos_nxt_s[i] = pos_r[i];
      end
    end
  end

  // Output decode. The PWM compare uses the committed position, giving a
  // high time of exactly pos cycles per frame, delayed by one cycle.
  // Busy looks at the next state so it drops together with the last move.
  always_comb begin
    pwm_nxt_s  = 5'b0_0000;
    busy_nxt_s = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      pwm_nxt_s[i] = (cnt_r < pos_r[i]);
      busy_nxt_s   = busy_nxt_s | (pos_nxt_s[i] != tgt_nxt_s[i]);
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r        <= {CW{1'b0}};
      pwm_r        <= 5'b0_0000;
      frame_tick_r <= 1'b0;
      busy_r       <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        pos_r[i] <= MIN_C;
        tgt_r[i] <= MIN_C;
      end
    end else begin
      cnt_r        <= cnt_nxt_s;
      pwm_r        <= pwm_nxt_s;
      frame_tick_r <= (cnt_nxt_s == LAST_C);
      busy_r       <= busy_nxt_s;
      for (int i = 0; i < NCH; i++) begin
        pos_r[i] <= pos_nxt_s[i];
        tgt_r[i] <= tgt_nxt_s[i];
      end
    end
  end

  assign servo_pwm  = pwm_r;
  assign frame_tick = frame_tick_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_gesture_servo_driver.sv
// -----------------------------------------------------------------------------
// tb_gesture_servo_driver
//
// Self-checking bench for gesture_servo_driver with a small frame
// (PERIOD_CYCLES=100, MIN_PULSE=10, MAX_PULSE=20, STEP=4). A frame-level
// reference model keeps the finger positions and targets as plain integers.
// It advances them once per frame boundary. Measured PWM high times,
// frame_tick and busy are compared against it. Honours GESTURE_SLEW_EN the
// same way the design does.
// -----------------------------------------------------------------------------
module tb_gesture_servo_driver;

  localparam int P    = 100;
  localparam int MINP = 10;
  localparam int MAXP = 20;
  localparam int STP  = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] gesture;
  logic [4:0] servo_pwm;
  logic       frame_tick;
  logic       busy;

  gesture_servo_driver #(
    .PERIOD_CYCLES(P),
    .MIN_PULSE    (MINP),
    .MAX_PULSE    (MAXP),
    .STEP         (STP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .gesture   (gesture),
    .servo_pwm (servo_pwm),
    .frame_tick(frame_tick),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int         m_pos[5];
  int         m_tgt[5];
  int         acc[5];
  int         last_high[5];
  int         m_cnt;
  bit         rst_prev;
  bit         bnd;
  logic [7:0] g_drv;
  bit         rst_drv;
  int         ramp_exp[5];

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 5; i++) begin
      m_pos[i] = MINP;
      m_tgt[i] = MINP;
      acc[i]   = 0;
    end
  endtask

  // One frame boundary: sample the gesture and move each finger.
  task automatic model_boundary(input logic [7:0] g);
    if (!g[7]) begin
      for (int i = 0; i < 5; i++) begin
        m_tgt[i] = g[i] ? MAXP : MINP;
`ifdef GESTURE_SLEW_EN
        if (m_tgt[i] - m_pos[i] > STP)      m_pos[i] = m_pos[i] + STP;
        else if (m_pos[i] - m_tgt[i] > STP) m_pos[i] = m_pos[i] - STP;
        else                                m_pos[i] = m_tgt[i];
`else
        m_pos[i] = m_tgt[i];
`endif
      end
    end
  endtask

  // One clock: sample at the falling edge, check, then drive the inputs
  // that the next rising edge will see.
  task automatic step();
    int exp_busy;
    @(negedge clk);
    bnd = 1'b0;
    if (rst_prev) m_cnt = 0;
    else          m_cnt = (m_cnt == P - 1) ? 0 : m_cnt + 1;

    if (rst_prev) begin
      check_eq("rst_pwm",  servo_pwm,  0);
      check_eq("rst_tick", frame_tick, 0);
      check_eq("rst_busy", busy,       0);
      model_reset();
    end else begin
      exp_busy = 0;
      for (int i = 0; i < 5; i++) if (m_pos[i] != m_tgt[i]) exp_busy = 1;
      check_eq("busy", busy, exp_busy);
      check_eq("frame_tick", frame_tick, (m_cnt == P - 1) ? 1 : 0);
      for (int i = 0; i < 5; i++) acc[i] = acc[i] + servo_pwm[i];
      if (m_cnt == P - 1) begin
        for (int i = 0; i < 5; i++) begin
          last_high[i] = acc[i];
          check_eq($sformatf("high_time[%0d]", i), acc[i], m_pos[i]);
          acc[i] = 0;
        end
      end
    end

    rst     = rst_drv;
    gesture = g_drv;
    if (!rst_prev && (m_cnt == P - 1) && !rst_drv) begin
      model_boundary(g_drv);
      bnd = 1'b1;
    end
    rst_prev = rst_drv;
  endtask

  task automatic run_frame();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!bnd && n < 2 * P);
  endtask

  task automatic run_to(input int c);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (m_cnt != c && n < 2 * P);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
`ifdef GESTURE_SLEW_EN
    ramp_exp = '{10, 14, 18, 20, 20};
`else
    ramp_exp = '{10, 20, 20, 20, 20};
`endif
    rst      = 1'b1;
    rst_drv  = 1'b1;
    rst_prev = 1'b1;
    gesture  = 8'hFF;
    g_drv    = 8'hFF;
    m_cnt    = 0;
    model_reset();
    for (int i = 0; i < 5; i++) last_high[i] = 0;

    // Reset with a junk gesture that must be ignored
    repeat (3) step();
    rst_drv = 1'b0;
    g_drv   = 8'h00;
    run_frame();
    run_frame();
    for (int i = 0; i < 5; i++) check_eq($sformatf("open_high[%0d]", i), last_high[i], MINP);

    // Close finger 0 and follow the ramp
    g_drv = 8'h01;
    for (int k = 0; k < 5; k++) begin
      run_frame();
      check_eq($sformatf("ramp0[%0d]", k), last_high[0], ramp_exp[k]);
      check_eq($sformatf("idle1[%0d]", k), last_high[1], MINP);
    end

    // Close all, reverse mid-ramp, settle
    g_drv = 8'h1F;
    run_frame();
    run_frame();
    g_drv = 8'h00;
    repeat (4) run_frame();

    // Freeze while part way up
    g_drv = 8'h01;
    run_frame();
    g_drv = 8'h81;
    repeat (2) run_frame();
    g_drv = 8'h01;
    repeat (3) run_frame();

    // Mid-frame glitch on the gesture must not reach the targets
    run_to(50);
    g_drv = 8'h1E;
    run_to(60);
    g_drv = 8'h01;
    repeat (2) run_frame();
    check_eq("glitch_high0", last_high[0], MAXP);
    check_eq("glitch_high1", last_high[1], MINP);

    // Reset at cycle 5 with finger 0 fully closed
    run_to(5);
    rst_drv = 1'b1;
    repeat (3) step();
    rst_drv = 1'b0;
    g_drv   = 8'h01;
    run_frame();
    check_eq("post_rst_high0", last_high[0], MINP);
    repeat (2) run_frame();

    // Randomised gestures, freezes and occasional resets
    for (int f = 0; f < 25; f++) begin
      g_drv = {($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0, 2'($urandom), 5'($urandom)};
      run_to($urandom_range(0, P - 1));
      g_drv = {($urandom_range(0, 5) == 0) ? 1'b1 : 1'b0, 2'($urandom), 5'($urandom)};
      if ($urandom_range(0, 9) == 0) begin
        rst_drv = 1'b1;
        repeat (2) step();
        rst_drv = 1'b0;
      end
      run_frame();
    end
    run_frame();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gesture_servo_driver.md
GESTURE_SERVO_DRIVER -- requirements
Module: gesture_servo_driver

Interface
REQ-001 Parameter PERIOD_CYCLES, default 1000000, servo frame length in clk cycles (20 ms at 50 MHz).
REQ-002 Parameter MIN_PULSE, default 50000, pulse width in cycles for an open finger (1 ms).
REQ-003 Parameter MAX_PULSE, default 100000, pulse width in cycles for a closed finger (2 ms).
REQ-004 Parameter STEP, default 2500, maximum pulse-width change per channel per frame.
REQ-005 Legal parameters: 1 <= STEP; MIN_PULSE < MAX_PULSE < PERIOD_CYCLES.
REQ-006 clk  input  1  system clock; one clock; all logic on rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 gesture  input  8  latched gesture code from the button-capture stage; [4:0] finger closed(1)/open(0), [7] freeze, [6:5] ignored.
REQ-009 servo_pwm  output  5  one PWM line per finger, bit i drives finger i.
REQ-010 frame_tick  output  1  single-cycle pulse on the last cycle of each frame.
REQ-011 busy  output  1  high while any channel position differs from its target.

Function
REQ-012 Frame counter counts 0..PERIOD_CYCLES-1, then wraps to 0; width = ceil(log2(PERIOD_CYCLES)).
REQ-013 frame_tick is registered; it is 1 exactly in the cycle where the counter equals PERIOD_CYCLES-1.
REQ-014 Targets are sampled only on the boundary cycle (counter == PERIOD_CYCLES-1): target[i] = gesture[i] ? MAX_PULSE : MIN_PULSE.
REQ-015 gesture value present on the boundary cycle is used; changes at any other cycle take effect at the next boundary only.
REQ-016 If gesture[7] == 1 on the boundary cycle, targets and positions hold their values for that frame.
REQ-017 On the boundary cycle, each position pos[i] moves toward target[i] by STEP; if |target-pos| <= STEP, pos[i] = target[i] (no overshoot).
REQ-018 Positions update only on boundary cycles; a pulse in progress is never truncated or extended mid-frame.
REQ-019 servo_pwm[i] is registered: 1 when counter < pos[i], else 0; one-cycle latency from counter to output.
REQ-020 Each servo_pwm[i] high time per frame equals the pos[i] value committed at the preceding boundary, exactly, in cycles.
REQ-021 busy is registered: 1 when any pos[i] != target[i], updated each cycle.
REQ-022 Channels are independent; simultaneous opposite moves on different fingers are permitted.

Reset
REQ-023 While rst is 1 on a clock edge: counter = 0, pos[i] = MIN_PULSE, target[i] = MIN_PULSE, servo_pwm = 0, frame_tick = 0, busy = 0.
REQ-024 Reset asserted mid-frame aborts the frame; the first frame after release starts at counter 0 with full MIN_PULSE pulses.
REQ-025 The gesture value is ignored during reset; the first sample is taken at the first boundary after release.

Configuration
REQ-026 Macro GESTURE_SLEW_EN defined: position updates are rate-limited per REQ-017.
REQ-027 Macro GESTURE_SLEW_EN undefined: on each non-frozen boundary, pos[i] = target[i] directly; STEP is unused; busy is 0 after the boundary cycle.

Verification (bench parameters: PERIOD_CYCLES=100, MIN_PULSE=10, MAX_PULSE=20, STEP=4)
REQ-028 Reset, then gesture=8'h00 -> frame_tick every 100 cycles; every servo_pwm bit is high for 10 cycles per frame; busy=0.
REQ-029 GESTURE_SLEW_EN set, gesture=8'h01 before a boundary -> bit 0 high times in successive frames are 14, 18, 20, 20; busy falls after the third boundary; bits 1-4 stay at 10.
REQ-030 gesture=8'h1F then 8'h00 mid-ramp (pos=18) -> bit high times in the next frames are 14, 10; there is no overshoot below 10.
REQ-031 gesture=8'h81 at a boundary while pos[0]=14 -> bit 0 high time stays 14 while frozen; after gesture=8'h01 it becomes 18, then 20.
REQ-032 gesture changes at cycle 50 and back at cycle 60 of a frame -> no effect on targets; pulse widths are unchanged.
REQ-033 rst pulsed at cycle 5 of a frame with pos[0]=20 -> all outputs are 0 during reset; the next frame gives 10-cycle pulses on every bit; GESTURE_SLEW_EN undefined, gesture=8'h01 -> bit 0 is 20 cycles in the first frame after the boundary.
